// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes, command layout and FSM states for the ALU issuer
package alu_pkg;

    localparam int OPCODE_W = 4;
    localparam int DATA_W   = 4;
    localparam int RES_W    = 8;

    localparam logic [OPCODE_W-1:0] OP_ADD    = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_SUB    = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_MUL    = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_DIV    = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_AND    = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_OR     = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_NOT    = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_NAND   = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_NOR    = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_XOR    = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_X_NOR  = 4'hA;
    localparam logic [OPCODE_W-1:0] LAST_LEGAL_OP = 4'hA;

    localparam int CMD_W = OPCODE_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
    } cmd_t;

    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        return op <= LAST_LEGAL_OP;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with full/empty flags
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_W = PTR_W + 1;

    logic [W-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               push_ok, pop_ok;

    assign full    = (count_q == COUNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap on natural overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + COUNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - queues ALU commands, drives the ALU, captures and screens results (ALU_ISSUER_STATS_EN adds counters)
module alu_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OPCODE_W-1:0] cmd_opcode,
    input  logic [DATA_W-1:0]   cmd_a,
    input  logic [DATA_W-1:0]   cmd_b,
    output logic [OPCODE_W-1:0] alu_opcode,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic [RES_W-1:0]    alu_op,
    input  logic                alu_flag,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [RES_W-1:0]    res_data,
    output logic                res_flag,
    output logic [OPCODE_W-1:0] res_opcode,
    output logic                res_err
`ifdef ALU_ISSUER_STATS_EN
    ,
    output logic [15:0]         stat_issued,
    output logic [15:0]         stat_errors
`endif
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OPCODE_W-1:0] alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [RES_W-1:0]    res_data_q, res_data_d;
    logic                res_flag_q, res_flag_d;
    logic [OPCODE_W-1:0] res_opcode_q, res_opcode_d;
    logic                res_err_q, res_err_d;
    logic                err_evt;

    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CMD_W-1:0]    fifo_rdata;
    cmd_t                head;

    // Gating with rst_n keeps cmd_ready low while reset is held
    assign cmd_ready = rst_n & ~fifo_full;
    assign fifo_push = cmd_valid & cmd_ready;
    assign head      = cmd_t'(fifo_rdata);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({cmd_opcode, cmd_a, cmd_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        res_data_d   = res_data_q;
        res_flag_d   = res_flag_q;
        res_opcode_d = res_opcode_q;
        res_err_d    = res_err_q;
        err_evt      = 1'b0;
        fifo_pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (is_legal(head.opcode)) begin
                        alu_opcode_d = head.opcode;
                        alu_a_d      = head.a;
                        alu_b_d      = head.b;
                        cnt_d        = CNT_W'(SETTLE);
                        state_d      = ISSUE;
                    end else begin
                        // Illegal opcodes never reach the ALU
                        res_data_d   = '0;
                        res_flag_d   = 1'b0;
                        res_opcode_d = head.opcode;
                        res_err_d    = 1'b1;
                        err_evt      = 1'b1;
                        state_d      = HOLD;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == CNT_W'(1)) begin
                    res_data_d   = alu_op;
                    res_flag_d   = ((alu_opcode_q == OP_ADD) || (alu_opcode_q == OP_SUB)) ? alu_flag : 1'b0;
                    res_opcode_d = alu_opcode_q;
                    res_err_d    = 1'b0;
                    if ((alu_opcode_q == OP_DIV) && (alu_b_q == '0)) begin
                        res_data_d = {RES_W{1'b1}};
                        res_err_d  = 1'b1;
                        err_evt    = 1'b1;
                    end
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            res_data_q   <= '0;
            res_flag_q   <= 1'b0;
            res_opcode_q <= '0;
            res_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            res_data_q   <= res_data_d;
            res_flag_q   <= res_flag_d;
            res_opcode_q <= res_opcode_d;
            res_err_q    <= res_err_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign res_valid  = (state_q == HOLD);
    assign res_data   = res_data_q;
    assign res_flag   = res_flag_q;
    assign res_opcode = res_opcode_q;
    assign res_err    = res_err_q;

`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] stat_issued_q, stat_issued_d;
    logic [15:0] stat_errors_q, stat_errors_d;

    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_errors_d = stat_errors_q;
        if (fifo_pop && (stat_issued_q != 16'hFFFF)) begin
            stat_issued_d = stat_issued_q + 16'd1;
        end
        if (err_evt && (stat_errors_q != 16'hFFFF)) begin
            stat_errors_d = stat_errors_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_errors_q <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_errors_q <= stat_errors_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_errors = stat_errors_q;
`else
    logic unused_err_evt;
    assign unused_err_evt = err_evt;
`endif

endmodule

// File: doc/alu_issuer.md
Name: alu_issuer

Overview:
Command-side front end for the 4-bit ALU datapath. It queues operation commands arriving on a valid/ready interface and drives opcode/operands onto the ALU's combinational inputs. After a fixed settle time it captures the ALU result and flag, then returns them on a valid/ready result interface. It also screens illegal opcodes and divide-by-zero before results reach the consumer.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
SETTLE, 1, cycles operands are held on the ALU before result capture (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; equals !full
cmd_opcode  input  4  operation code
cmd_a  input  4  operand A
cmd_b  input  4  operand B
alu_opcode  output  4  opcode driven to ALU
alu_a  output  4  operand A driven to ALU
alu_b  output  4  operand B driven to ALU
alu_op  input  8  ALU result
alu_flag  input  1  ALU carry/borrow flag
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  8  captured result
res_flag  output  1  captured flag
res_opcode  output  4  opcode this result belongs to
res_err  output  1  illegal opcode or divide-by-zero

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low on rst_n. Reset clears FIFO pointers and count, FSM->IDLE, all outputs 0 (cmd_ready=1 once out of reset), discarding queued commands and any in-flight operation.
- Push: cmd_valid & cmd_ready at a clk edge writes {opcode,a,b}. Full: cmd_ready=0, no push even if a pop occurs the same cycle. Pointers wrap modulo DEPTH.
- Legal opcodes: 0x0-0xA (add, sub, mul, div, and, or, not, nand, nor, xor, xnor). 0xB-0xF are illegal.
- FSM IDLE: if FIFO is non-empty, pop the head.
  - Legal opcode: load alu_opcode/alu_a/alu_b, load settle counter=SETTLE, go ISSUE.
  - Illegal opcode: leave ALU outputs unchanged, load res_data=0, res_flag=0, res_err=1, res_opcode, go HOLD.
- FSM ISSUE: counter decrements each cycle. On the cycle it reads 1, sample the result and go HOLD:
  - res_data=alu_op.
  - res_flag=alu_flag for opcode 0x0/0x1, else 0.
  - res_opcode=alu_opcode; res_err=0.
  - Exception: div (0x3) with alu_b==0 gives res_data=8'hFF, res_err=1.
- FSM HOLD: res_valid=1, all res_* stable. When res_ready=1, drop res_valid next cycle and go IDLE. res_valid is registered and reflects state HOLD.
- alu_opcode/alu_a/alu_b change only on IDLE pop of a legal command; otherwise they hold the last value.
- Latency: push at edge N gives res_valid high after edge N+1+SETTLE. Illegal opcode: after edge N+1.
- Throughput: one result per SETTLE+2 cycles with res_ready tied high.
- Ordering: results are returned strictly in command order.
- Pushes continue during ISSUE/HOLD until full.

Optional Feature:
ALU_ISSUER_STATS_EN:
- Defined: adds outputs stat_issued[15:0] (commands popped) and stat_errors[15:0] (results with res_err=1). Both saturate at 16'hFFFF and clear on reset; each increments on its event edge.
- Undefined: the ports and counters are absent, with no other behavioural change.

Decomposition:
- Package alu_pkg: OPCODE_W=4, DATA_W=4, RES_W=8, the eleven opcode constants (add=4'h0 ... x_nor=4'hA), LAST_LEGAL_OP=4'hA, and the FSM state enum {IDLE, ISSUE, HOLD}.
- Sub-module alu_cmd_fifo: synchronous FIFO, 12-bit payload, DEPTH parameter, full/empty flags.
- FSM and result capture stay in alu_issuer.

Test Plan:
- Single add: reset, push op=0x0 a=3 b=5; bench ALU model returns 8 -> alu_* = 0/3/5 one cycle after push; res_valid after edge N+2 (SETTLE=1); res_data=8, res_err=0.
- Illegal opcode: push 0xC -> res_valid after edge N+1; res_data=0, res_err=1; alu_* unchanged from prior values.
- Divide by zero: push op=0x3 a=9 b=0 -> res_data=8'hFF, res_err=1. Then push op=0x3 a=9 b=2 -> res_data=4, res_err=0.
- Backpressure/full: hold res_ready=0 and push 6 commands with DEPTH=4.
  - After 5 accepts (4 queued + 1 in HOLD), cmd_ready=0.
  - Release res_ready: 5 results return in order.
  - cmd_ready reasserts one cycle after the first pop.
- Reset mid-operation: assert rst_n=0 while in ISSUE with 2 queued commands -> all outputs 0 immediately. After release, no stale results; cmd_ready=1.
- Stats (ALU_ISSUER_STATS_EN): 3 legal commands, 1 illegal, 1 div-by-zero -> stat_issued=5, stat_errors=2.
